// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
// Control word bit positions and status word bit positions.
package booth_pkg;

  localparam int CTL_W = 10;

  localparam int CTL_LD_A     = 9;
  localparam int CTL_LD_B     = 8;
  localparam int CTL_LD_CONT  = 7;
  localparam int CTL_SET_EF   = 6;
  localparam int CTL_RST_X    = 5;
  localparam int CTL_RST_EF   = 4;
  localparam int CTL_SUB_X    = 3;
  localparam int CTL_SUB_CONT = 2;
  localparam int CTL_ADD_X    = 1;
  localparam int CTL_SHIFT_XB = 0;

  localparam int ST_B0  = 1;
  localparam int ST_FIN = 0;

  typedef logic [CTL_W-1:0] ctl_t;

endpackage

// File: rtl/booth_datapath_if.sv
// Control unit <-> datapath bundle for the Booth multiplier.
// master = control unit side, slave = datapath side.
interface booth_datapath_if #(
  parameter int N = 8
);
  import booth_pkg::*;

  ctl_t           control;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic [1:0]     status;
  logic [2*N-1:0] product;
  logic           done;

  modport master (
    output control, a_in, b_in,
    input  status, product, done
  );

  modport slave (
    input  control, a_in, b_in,
    output status, product, done
  );

endinterface

// File: rtl/booth_addsub.sv
// (N+1)-bit add/subtract of accumulator X and sign-extended A.
// Purely combinational.
module booth_addsub #(
  parameter int N = 8
) (
  input  logic [N:0]   x,
  input  logic [N-1:0] a,
  input  logic         sub,
  output logic [N:0]   y
);

  logic [N:0] a_ext;

  assign a_ext = {a[N-1], a};
  assign y = sub ? (x - a_ext) : (x + a_ext);

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: A, B, X, CONT and EF registers,
// driven by the control word, reporting {B0, FIN} back.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rstn,
  booth_datapath_if.slave bus
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N:0]    x_q;
  logic [CW-1:0] cont_q;
  logic          ef_q;

  ctl_t       c;
  logic       arith;
  logic       shift_en;
  logic [N:0] x_sum;
  logic       b0;

  assign c        = bus.control;
  assign arith    = c[CTL_SUB_X] | c[CTL_ADD_X];
  assign shift_en = c[CTL_SHIFT_XB] & ~c[CTL_RST_X] & ~arith;

  booth_addsub #(.N(N)) u_addsub (
    .x   (x_q),
    .a   (a_q),
    .sub (c[CTL_SUB_X]),
    .y   (x_sum)
  );

  // Bit the control unit inspects next, looking through this cycle's update
  always_comb begin
    b0 = b_q[0];
    unique case (1'b1)
      c[CTL_LD_B]: b0 = bus.b_in[0];
      shift_en:    b0 = b_q[1];
      default:     b0 = b_q[0];
    endcase
  end

  assign bus.status  = {b0, (cont_q == '0)};
  assign bus.product = {x_q[N-1:0], b_q};
  assign bus.done    = ef_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q    <= '0;
      b_q    <= '0;
      x_q    <= '0;
      cont_q <= '0;
      ef_q   <= 1'b0;
    end else begin
      if (c[CTL_LD_A])
        a_q <= bus.a_in;

      if (c[CTL_RST_X])
        x_q <= '0;
      else if (arith)
        x_q <= x_sum;
      else if (c[CTL_SHIFT_XB])
        x_q <= {x_q[N], x_q[N:1]};

      if (c[CTL_LD_B])
        b_q <= bus.b_in;
      else if (shift_en)
        b_q <= {x_q[0], b_q[N-1:1]};

      if (c[CTL_LD_CONT])
        cont_q <= CW'(N - 1);
      else if (c[CTL_SUB_CONT])
        cont_q <= cont_q - CW'(1);

      if (c[CTL_RST_EF])
        ef_q <= 1'b0;
      else if (c[CTL_SET_EF])
        ef_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_datapath.sv
// Bench for booth_datapath: a behavioural control unit sequences
// multiplications; a scoreboard queue holds the expected products.
module tb_booth_datapath;
  import booth_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] sb[$];

  booth_datapath_if #(.N(N)) bus ();

  booth_datapath #(.N(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t bit_of(int idx);
    ctl_t r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one control word for one clock; outputs sampled #1 after the edge
  task automatic step(ctl_t c);
    @(negedge clk);
    bus.control = c;
    @(posedge clk);
    #1;
  endtask

  task automatic run(logic [7:0] a, logic [7:0] b,
                     logic [15:0] exp, int abort_at);
    logic q, b0, fin;
    int shifts;
    bit aborted;
    ctl_t c;
    q = 1'b0;
    shifts = 0;
    aborted = 1'b0;
    @(negedge clk);
    bus.a_in = a;
    bus.b_in = b;
    bus.control = bit_of(CTL_LD_A) | bit_of(CTL_LD_B) |
                  bit_of(CTL_LD_CONT) | bit_of(CTL_RST_X) |
                  bit_of(CTL_RST_EF);
    sb.push_back(exp);
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      bus.control = '0;
      #1;
      b0 = bus.status[ST_B0];
      if (b0 && !q) begin
        bus.control = bit_of(CTL_SUB_X);
        @(negedge clk);
      end else if (!b0 && q) begin
        bus.control = bit_of(CTL_ADD_X);
        @(negedge clk);
      end
      c = bit_of(CTL_SHIFT_XB) | bit_of(CTL_SUB_CONT);
      bus.control = c;
      #1;
      fin = bus.status[ST_FIN];
      check($sformatf("fin_shift%0d", i), 32'(fin), 32'(i == N));
      if (fin)
        bus.control = c | bit_of(CTL_SET_EF);
      shifts++;
      q = b0;
      if (i == abort_at) begin
        rstn = 1'b0;
        #1;
        check("abort_product", 32'(bus.product), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_status", 32'(bus.status), 32'h1);
        aborted = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.control = '0;
    if (aborted) begin
      void'(sb.pop_back());
      rstn = 1'b1;
      return;
    end
    for (int k = 0; k < 20 && !bus.done; k++)
      @(negedge clk);
    check("done_rise", 32'(bus.done), 32'h1);
    check("shift_count", 32'(shifts), 32'(N));
    if (sb.size() == 0) begin
      check("sb_empty", 32'(0), 32'(1));
    end else begin
      check($sformatf("product_%h_x_%h", a, b),
            32'(bus.product), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    bus.control = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    #12;
    check("rst_product", 32'(bus.product), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_status", 32'(bus.status), 32'h1);
    @(negedge clk);
    rstn = 1'b1;

    run(8'd3, 8'd5, 16'h000F, 0);
    run(8'hFD, 8'd5, 16'hFFF1, 0);
    run(8'd7, 8'hFF, 16'hFFF9, 0);
    run(8'h80, 8'h80, 16'h4000, 0);

    // X priority: RST_X beats SUB_X
    bus.a_in = 8'd5;
    step(bit_of(CTL_LD_A) | bit_of(CTL_RST_X));
    step(bit_of(CTL_ADD_X));
    check("x_add", 32'(bus.product[15:8]), 32'h05);
    step(bit_of(CTL_RST_X) | bit_of(CTL_SUB_X));
    check("x_rst_over_sub", 32'(bus.product[15:8]), 32'h00);
    step(bit_of(CTL_SUB_X));
    check("x_sub", 32'(bus.product[15:8]), 32'hFB);

    // CONT: load overrides decrement, then wrap from 0
    step(bit_of(CTL_LD_CONT) | bit_of(CTL_SUB_CONT));
    check("cont_load7", 32'(bus.status[ST_FIN]), 32'h0);
    for (int i = 0; i < 6; i++)
      step(bit_of(CTL_SUB_CONT));
    check("cont_at1", 32'(bus.status[ST_FIN]), 32'h0);
    step(bit_of(CTL_SUB_CONT));
    check("cont_at0", 32'(bus.status[ST_FIN]), 32'h1);
    step(bit_of(CTL_SUB_CONT));
    check("cont_wrap", 32'(bus.status[ST_FIN]), 32'h0);
    for (int i = 0; i < 6; i++)
      step(bit_of(CTL_SUB_CONT));
    check("cont_wrap_at1", 32'(bus.status[ST_FIN]), 32'h0);
    step(bit_of(CTL_SUB_CONT));
    check("cont_wrap_at0", 32'(bus.status[ST_FIN]), 32'h1);

    // EF: RST_EF wins over SET_EF
    step(bit_of(CTL_SET_EF));
    check("ef_set", 32'(bus.done), 32'h1);
    step(bit_of(CTL_SET_EF) | bit_of(CTL_RST_EF));
    check("ef_rst_over_set", 32'(bus.done), 32'h0);

    // B0 lookahead
    @(negedge clk);
    bus.b_in = 8'h01;
    bus.control = bit_of(CTL_LD_B);
    #1;
    check("b0_ld_b", 32'(bus.status[ST_B0]), 32'h1);
    bus.b_in = 8'h02;
    @(posedge clk);
    @(negedge clk);
    bus.control = bit_of(CTL_SHIFT_XB);
    #1;
    check("b0_shift", 32'(bus.status[ST_B0]), 32'h1);
    bus.control = bit_of(CTL_SHIFT_XB) | bit_of(CTL_ADD_X);
    #1;
    check("b0_shift_suppressed", 32'(bus.status[ST_B0]), 32'h0);
    bus.control = '0;
    #1;
    check("b0_idle", 32'(bus.status[ST_B0]), 32'h0);

    // Abort on the 4th shift, then a clean run
    run(8'd3, 8'd5, 16'h000F, 4);
    run(8'd6, 8'd7, 16'h002A, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_datapath.md
# booth_datapath

Datapath for the radix-2 Booth signed multiplier. Executes the 10-bit control word issued by the multiplier control unit and returns the 2-bit status word (`B0`, `FIN`) that the control unit uses for its next-state decisions. Holds the multiplicand, multiplier/low-product, accumulator, iteration counter and end flag, and presents the signed 2N-bit product.

## Interface
- `N`, default 8: operand width in bits, signed two's complement; minimum 2.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  reset, asynchronous, active-low; clock `clk`.
- `control`  in  10  control word, bit 9..0 = `LD_A`, `LD_B`, `LD_CONT`, `SET_EF`, `RST_X`, `RST_EF`, `SUB_X`, `SUB_CONT`, `ADD_X`, `SHIFT_XB`.
- `a_in`  in  N  multiplicand, sampled on `LD_A`.
- `b_in`  in  N  multiplier, sampled on `LD_B`.
- `status`  out  2  {`B0`, `FIN`}; combinational.
- `product`  out  2N  signed product {X, B} low 2N bits; valid while `done`=1.
- `done`  out  1  end flag EF (registered).

## Operation
- Registers: A (N), B (N), X accumulator (N+1, sign-extended, guards the −2^(N−1) subtract overflow), CONT (`$clog2(N)` bits), EF (1).
- `LD_A`: A ← `a_in`. `LD_B`: B ← `b_in`. `LD_CONT`: CONT ← N−1.
- X update, priority high→low: `RST_X`: X ← 0; `SUB_X`: X ← X − sext(A); `ADD_X`: X ← X + sext(A); `SHIFT_XB`: {X,B} ← arithmetic shift right by 1 of the (2N+1)-bit {X,B}, X MSB replicated. Only the highest-priority X operation takes effect in a cycle; when `SHIFT_XB` is suppressed, B is also unchanged. `LD_B` overrides the B half of a shift.
- `SUB_CONT`: CONT ← CONT − 1, wraps modulo 2^width. `LD_CONT` overrides `SUB_CONT`.
- EF: `RST_EF` clears and overrides `SET_EF`; `SET_EF` sets; otherwise EF holds.
- `FIN` = (CONT == 0).
- `B0` selects the multiplier bit the control unit examines next: `b_in[0]` when `LD_B`=1; else B[1] when the shift takes effect this cycle (`SHIFT_XB`=1 with no `RST_X`/`SUB_X`/`ADD_X`); else B[0].
- `product` = {X[N−1:0], B}; `done` = EF. Both are driven continuously. `product` is defined only while `done`=1.
- A multiplication performs exactly N shifts. CONT loaded with N−1 makes `FIN`=1 during the Nth shift cycle.

## Timing
- Reset values: A=B=X=0, CONT=0, EF=0. This gives `product`=0, `done`=0, `status`=2'b01 (`B0`=0, `FIN`=1).
- Every register update is applied on the rising edge of the cycle in which its control bit is high. No internal pipelining.
- `status` is combinational from registers, `control` and `b_in`, with zero-cycle latency, so the control unit's next-state logic sees it in the same cycle.
- `done` rises on the edge that ends the cycle with `SET_EF`. It falls on the edge that ends the cycle with `RST_EF` (next start).
- Reset asserted mid-operation clears every register asynchronously. An operation in progress is abandoned with no partial result retained.

## Structure
- The shared package `booth_pkg` holds:
  - the control-bit index constants (`CTL_LD_A`=9 … `CTL_SHIFT_XB`=0);
  - the status indices (`ST_B0`=1, `ST_FIN`=0);
  - a `ctl_t` typedef for the 10-bit word.
- The control unit imports the same package.
- One sub-module, `booth_addsub`: an (N+1)-bit combinational add/subtract of X and sext(A).
- All registers live in `booth_datapath`.

## Test plan
- N=8, paired with the control unit. Apply reset, then `start` with a=3, b=5. Required: `done` rises; `product`=16'h000F; exactly 8 `SHIFT_XB` cycles are observed.
- a=−3 (8'hFD), b=5. Required: `product`=16'hFFF1. Also a=7, b=−1. Required: `product`=16'hFFF9.
- a=−128, b=−128. Required: `product`=16'h4000, with no accumulator overflow.
- Standalone, control driven directly:
  - Drive `RST_X`|`SUB_X` in one cycle. Required: X=0.
  - Drive `LD_CONT`|`SUB_CONT`. Required: CONT=7.
  - Drive `SET_EF`|`RST_EF`. Required: EF=0.
  - Drive `SUB_CONT` with CONT=0. Required: CONT wraps to 7.
- `status` check:
  - With `LD_B`=1 and `b_in`=8'h01. Required: `B0`=1 in the same cycle.
  - With B=8'b10 and a `SHIFT_XB` taking effect. Required: `B0`=1.
  - With B=8'b10 and idle control. Required: `B0`=0.
- Pull `rstn` low during the 4th shift of a=3, b=5. Required: immediately `product`=0, `done`=0, `status`=2'b01. A subsequent 6×7 run gives 16'h002A.
